// File: rtl/elevator_pkg.sv
// Shared types and helpers for the SCAN elevator controller.
package elevator_pkg;

    // Widest pending mask the scan helper accepts; NUM_FLOORS must not exceed this.
    localparam int MAX_FLOORS = 32;

    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StMoveUp = 3'd1,
        StMoveDn = 3'd2,
        StDoor   = 3'd3,
        StHalt   = 3'd4
    } state_t;

    typedef struct packed {
        logic above;
        logic below;
    } scan_t;

    typedef struct packed {
        state_t st;
        logic   up;
    } decision_t;

    // Reports whether any call lies above or below the given floor.
    function automatic scan_t scan_calls(logic [MAX_FLOORS-1:0] mask, int floor);
        scan_t r;
        r.above = 1'b0;
        r.below = 1'b0;
        for (int i = 0; i < MAX_FLOORS; i++) begin
            if (mask[i] && (i > floor)) r.above = 1'b1;
            if (mask[i] && (i < floor)) r.below = 1'b1;
        end
        return r;
    endfunction

    // SCAN choice: serve here, else keep heading, else reverse, else rest.
    function automatic decision_t scan_decide(logic here, logic above, logic below, logic up);
        decision_t d;
        d.up = up;
        if (here) begin
            d.st = StDoor;
        end else if (up ? above : below) begin
            d.st = up ? StMoveUp : StMoveDn;
        end else if (up ? below : above) begin
            d.up = ~up;
            d.st = up ? StMoveDn : StMoveUp;
        end else begin
            d.st = StIdle;
        end
        return d;
    endfunction

endpackage

// File: rtl/elevator_call_scan.sv
// Classifies outstanding calls relative to the car's current floor.
module elevator_call_scan
    import elevator_pkg::*;
#(
    parameter int unsigned NUM_FLOORS = 8,
    parameter int unsigned FLOOR_W    = $clog2(NUM_FLOORS)
) (
    input  logic [NUM_FLOORS-1:0] pending,
    input  logic [FLOOR_W-1:0]    cur_floor,
    output logic                  here,
    output logic                  above,
    output logic                  below
);

    scan_t sc;

    // Scan the mask around the current floor.
    always_comb begin
        sc    = scan_calls(MAX_FLOORS'(pending), int'(cur_floor));
        here  = |(pending & (NUM_FLOORS'(1) << cur_floor));
        above = sc.above;
        below = sc.below;
    end

endmodule

// File: rtl/elevator_scan_controller.sv
// N-floor elevator controller: latched calls served in SCAN order, manual
// step mode, travel/door timers and an emergency stop.
module elevator_scan_controller
    import elevator_pkg::*;
#(
    parameter int unsigned NUM_FLOORS    = 8,
    parameter int unsigned FLOOR_W       = $clog2(NUM_FLOORS),
    parameter int unsigned TRAVEL_CYCLES = 2,
    parameter int unsigned DOOR_CYCLES   = 4
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  Control_TYPE,
    input  logic                  UPDN,
    input  logic [NUM_FLOORS-1:0] call_req,
    input  logic                  estop,
    output logic [FLOOR_W-1:0]    cur_floor,
    output logic                  door_open,
    output logic                  dir_up,
    output logic [NUM_FLOORS-1:0] pending,
    output logic [2:0]            state,
    output logic [2:0]            next_state
);

    localparam int unsigned TCW = (TRAVEL_CYCLES > 1) ? $clog2(TRAVEL_CYCLES) : 1;
    localparam int unsigned DCW = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;

    state_t                state_q, state_d;
    logic [FLOOR_W-1:0]    floor_q, floor_d;
    logic                  dir_q, dir_d;
    logic [NUM_FLOORS-1:0] pending_q, pending_d;
    logic [TCW-1:0]        travel_q, travel_d;
    logic [DCW-1:0]        dwell_q, dwell_d;
    logic                  manual_q, manual_d;
    logic                  door_open_q;

    logic                  here, above, below;
    logic [FLOOR_W-1:0]    arr_floor;
    logic                  arr_here;
    scan_t                 arr_scan;
    decision_t             dec;
    logic [NUM_FLOORS-1:0] clear_mask;
    logic                  at_top, at_bot;

    elevator_call_scan #(
        .NUM_FLOORS (NUM_FLOORS),
        .FLOOR_W    (FLOOR_W)
    ) u_call_scan (
        .pending   (pending_q),
        .cur_floor (floor_q),
        .here      (here),
        .above     (above),
        .below     (below)
    );

    // Floor the car lands on at the end of the current travel step.
    always_comb begin
        arr_floor = (state_q == StMoveDn) ? floor_q - FLOOR_W'(1) : floor_q + FLOOR_W'(1);
        arr_here  = |(pending_q & (NUM_FLOORS'(1) << arr_floor));
        arr_scan  = scan_calls(MAX_FLOORS'(pending_q), int'(arr_floor));
        at_top    = (floor_q == FLOOR_W'(NUM_FLOORS - 1));
        at_bot    = (floor_q == '0);
    end

    // Next-state, counter and call-clear decisions.
    always_comb begin
        state_d    = state_q;
        floor_d    = floor_q;
        dir_d      = dir_q;
        travel_d   = travel_q;
        dwell_d    = dwell_q;
        manual_d   = manual_q;
        clear_mask = '0;
        dec        = '{st: StIdle, up: dir_q};

        case (state_q)
            StIdle: begin
                travel_d = '0;
                dwell_d  = '0;
                if (!Control_TYPE) begin
                    // Manual mode latches here so a run keeps stepping until an end floor.
                    manual_d = 1'b1;
                    if (UPDN && !at_top) begin
                        state_d = StMoveUp;
                        dir_d   = DIR_UP;
                    end else if (!UPDN && !at_bot) begin
                        state_d = StMoveDn;
                        dir_d   = DIR_DN;
                    end
                end else begin
                    manual_d = 1'b0;
                    dec      = scan_decide(here, above, below, dir_q);
                    state_d  = dec.st;
                    dir_d    = dec.up;
                    if (dec.st == StDoor) clear_mask = NUM_FLOORS'(1) << floor_q;
                end
            end

            StMoveUp, StMoveDn: begin
                if (travel_q == TCW'(TRAVEL_CYCLES - 1)) begin
                    travel_d = '0;
                    floor_d  = arr_floor;
                    if (manual_q) begin
                        if ((state_q == StMoveUp && arr_floor == FLOOR_W'(NUM_FLOORS - 1)) ||
                            (state_q == StMoveDn && arr_floor == '0)) begin
                            state_d = StIdle;
                        end
                    end else begin
                        dec     = scan_decide(arr_here, arr_scan.above, arr_scan.below, dir_q);
                        state_d = dec.st;
                        dir_d   = dec.up;
                        dwell_d = '0;
                        if (dec.st == StDoor) clear_mask = NUM_FLOORS'(1) << arr_floor;
                    end
                end else begin
                    travel_d = travel_q + TCW'(1);
                end
            end

            StDoor: begin
                // A call to the open floor is absorbed and holds the door instead.
                clear_mask = NUM_FLOORS'(1) << floor_q;
                travel_d   = '0;
                if (|(call_req & clear_mask)) begin
                    dwell_d = '0;
                end else if (dwell_q == DCW'(DOOR_CYCLES - 1)) begin
                    dwell_d = '0;
                    dec     = scan_decide(here, above, below, dir_q);
                    state_d = dec.st;
                    dir_d   = dec.up;
                end else begin
                    dwell_d = dwell_q + DCW'(1);
                end
            end

            StHalt: begin
                if (!estop) state_d = StIdle;
            end

            default: state_d = StIdle;
        endcase

        if (estop) begin
            state_d    = StHalt;
            floor_d    = floor_q;
            dir_d      = dir_q;
            manual_d   = manual_q;
            travel_d   = '0;
            dwell_d    = '0;
            clear_mask = '0;
        end

        pending_d = (pending_q | call_req) & ~clear_mask;
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= StIdle;
            floor_q     <= '0;
            dir_q       <= DIR_UP;
            pending_q   <= '0;
            travel_q    <= '0;
            dwell_q     <= '0;
            manual_q    <= 1'b0;
            door_open_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            floor_q     <= floor_d;
            dir_q       <= dir_d;
            pending_q   <= pending_d;
            travel_q    <= travel_d;
            dwell_q     <= dwell_d;
            manual_q    <= manual_d;
            door_open_q <= (state_d == StDoor);
        end
    end

    assign cur_floor  = floor_q;
    assign door_open  = door_open_q;
    assign dir_up     = dir_q;
    assign pending    = pending_q;
    assign state      = state_q;
    assign next_state = RESET ? StIdle : state_d;

endmodule

// File: doc/elevator_scan_controller.md
Name: elevator_scan_controller

Overview:
- Parametrised successor to the 5-floor elevator FSM, for N floors.
- Latches multiple floor calls into a pending bitmask and serves them with a SCAN (collective) policy: it keeps its current direction while calls remain ahead, then reverses.
- Adds travel-time and door-dwell counters, an emergency stop, and retains the manual UP/DOWN step mode.
- Drives the car position/door indicators and exposes FSM state for the display/debug layer.

Parameters:
- NUM_FLOORS, 8, number of floors (>=2), floor 0 = ground.
- FLOOR_W, $clog2(NUM_FLOORS), width of floor index.
- TRAVEL_CYCLES, 2, clocks to move one floor (>=1).
- DOOR_CYCLES, 4, clocks door stays open (>=1).

Ports:
- CLK  in  1  clock; all logic on posedge.
- RESET  in  1  synchronous, active-high reset.
- Control_TYPE  in  1  0 = manual step mode, 1 = automatic SCAN mode.
- UPDN  in  1  manual direction: 1 = up, 0 = down.
- call_req  in  NUM_FLOORS  per-floor call pulses (any number of bits at once).
- estop  in  1  emergency stop, level-sensitive.
- cur_floor  out  FLOOR_W  current floor index.
- door_open  out  1  door open indicator.
- dir_up  out  1  last/current travel direction (1 = up).
- pending  out  NUM_FLOORS  registered outstanding calls.
- state  out  3  current FSM state.
- next_state  out  3  combinational next state.

Behaviour:
- Reset: one clock, synchronous, active-high (CLK/RESET).
  - state=IDLE, cur_floor=0, door_open=0, dir_up=1, pending=0, both counters=0.
  - RESET mid-travel or mid-door abandons the operation, with no partial floor step.
- States:
  - IDLE=0, MOVE_UP=1, MOVE_DN=2, DOOR=3, HALT=4.
  - door_open=1 only in DOOR.
- Call latch:
  - pending <= (pending | call_req) & ~clear_mask every cycle.
  - A call arriving in the same cycle as its clear is dropped if it targets cur_floor while in DOOR; in that case the door timer restarts instead.
- Decisions use registered pending only. A call sampled at edge k can change state at edge k+1 at the earliest.
- IDLE (Control_TYPE=1):
  - pending[cur_floor] -> DOOR, clearing that bit.
  - Else a call ahead in dir_up's direction -> move that way.
  - Else a call behind -> reverse dir_up and move.
  - Else stay IDLE.
- MOVE_UP / MOVE_DN:
  - The travel counter counts 0..TRAVEL_CYCLES-1. On terminal count, cur_floor changes by ±1 and the counter clears.
  - On arrival, if pending[new floor] -> DOOR (bit cleared on that edge).
  - Else continue if calls remain ahead.
  - Else reverse if calls exist behind.
  - Else IDLE.
- DOOR:
  - Dwell counter runs DOOR_CYCLES clocks, then the IDLE decision rules apply: continue same direction first, reverse, or idle.
  - A new call to cur_floor restarts the dwell counter.
- Boundaries:
  - cur_floor never exceeds NUM_FLOORS-1 or goes below 0.
  - At a top/bottom end with no further call, the FSM goes to IDLE and never wraps.
- Manual mode (Control_TYPE=0):
  - Sampled only in IDLE.
  - Moves one floor per TRAVEL_CYCLES in the UPDN direction, with dir_up=UPDN.
  - At floor NUM_FLOORS-1 with UPDN=1, or floor 0 with UPDN=0, the FSM holds IDLE.
  - Calls still latch into pending but are not served; no DOOR entry.
- estop:
  - Any state -> HALT on the next edge; door_open=0 and counters cleared.
  - cur_floor unchanged; partial travel progress is discarded.
  - On deassertion, HALT -> IDLE; pending is retained.
  - RESET overrides estop.
- Simultaneous events: precedence is RESET > estop > arrival/door logic > new calls.

Decomposition:
- Package elevator_pkg holds:
  - state encodings (IDLE..HALT, 3-bit);
  - the direction constants;
  - a function returning any_above/any_below for a pending mask and floor index.
- One natural sub-module: elevator_call_scan.
  - Combinational.
  - Inputs: pending, cur_floor. Outputs: here, above, below.

Test Plan:
- Test config: NUM_FLOORS=8, TRAVEL_CYCLES=2, DOOR_CYCLES=4.
- Reset: RESET=1 for one edge -> cur_floor=0, state=0, door_open=0, pending=0, dir_up=1.
- Single call:
  - Stimulus: call_req=8'b0000_1000 pulse at floor 0.
  - Required: pending[3]=1 next cycle; MOVE_UP; cur_floor reaches 3 six clocks after entering MOVE_UP.
  - Then DOOR for 4 clocks with pending[3] cleared, then IDLE.
- SCAN ordering:
  - Stimulus: at floor 2 moving up, calls at floors 5 and 0.
  - Required: the car serves 5 first (door opens at 5), then reverses with dir_up=0 and serves 0, then IDLE.
- Door re-open: call to cur_floor=4 on dwell clock 3 -> dwell restarts; door_open stays high 4 more clocks; pending[4] never set.
- Emergency stop:
  - Stimulus: estop=1 mid-travel from floor 1 to 2.
  - Required: HALT next edge, cur_floor=1, pending preserved.
  - On release: IDLE, then MOVE_UP resumes and the full 2-cycle travel to floor 2 occurs.
- Manual mode:
  - Stimulus: Control_TYPE=0, UPDN=1 from floor 0.
  - Required: the car steps 0->7 every 2 clocks, then holds IDLE at 7.
  - Then UPDN=0: the car steps down to 0 and holds; door_open stays 0 throughout.
